// File: rtl/alu_seq_if.sv
// Operation/result bundle for alu_seq; slave = ALU, master = issuing and consuming stage.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid,
// once raised, holds its payload stable until that edge; ready may depend combinationally on the
// other side's signals.
interface alu_seq_if #(parameter int WIDTH = 16);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             out_wr;
  logic             flag_s;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic             halted;
  logic [1:0]       dbg_state;

  modport master (
    output in_valid, opcode, a, b, shamt, flush, out_ready,
    input  in_ready, out_valid, result, out_wr, flag_s, flag_z, flag_c, flag_v, halted, dbg_state
  );

  modport slave (
    input  in_valid, opcode, a, b, shamt, flush, out_ready,
    output in_ready, out_valid, result, out_wr, flag_s, flag_z, flag_c, flag_v, halted, dbg_state
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arith/logic, bit-serial shifts, registered S/Z/C/V and sticky halt.
// Define ALU_MUL_EN to add the WIDTH-cycle shift-add multiplier on opcode 12.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_CMP = 4'd5,  OP_MOV = 4'd6,  OP_SLL = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9,  OP_SRL = 4'd10, OP_SRA = 4'd11, OP_HLT = 4'd15;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [SHW:0] CNT_MUL = {1'b1, {SHW{1'b0}}};
`endif
  localparam logic [SHW:0] CNT_LAST = {{SHW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef ALU_MUL_EN
    MUL   = 2'd2,
`endif
    DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] result_q, sh_q, sh_d;
  logic             out_wr_q, fs_q, fz_q, fc_q, fv_q, halted_q, shc_d;
  logic [1:0]       sop_q;
  logic [SHW:0]     cnt_q;

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] alu_res, alu_fres;
  logic             alu_c, alu_v, alu_upd, alu_wr, start_shift;
  logic             in_ready_w, accept;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mul_q, mul_d;
  logic [WIDTH-1:0]   mca_q;
  logic [WIDTH:0]     mul_sum;
  logic               start_mul;
`endif

  assign in_ready_w = ((state_q == IDLE) || (state_q == DONE && bus.out_ready))
                      && !halted_q && !bus.flush;
  assign accept     = bus.in_valid && in_ready_w;

  assign add_w = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_w = {1'b0, bus.a} - {1'b0, bus.b};

  // Decode of the op being accepted; alu_fres is what S/Z look at (differs from result for CMP).
  always_comb begin
    alu_res     = '0;
    alu_fres    = '0;
    alu_c       = 1'b0;
    alu_v       = 1'b0;
    alu_upd     = 1'b0;
    alu_wr      = 1'b0;
    start_shift = 1'b0;
`ifdef ALU_MUL_EN
    start_mul   = 1'b0;
`endif
    case (bus.opcode)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_w[WIDTH-1] != bus.a[WIDTH-1]);
        alu_upd = 1'b1;
        alu_wr  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_res = (bus.opcode == OP_CMP) ? bus.a : sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
        alu_upd = 1'b1;
        alu_wr  = (bus.opcode == OP_SUB);
      end
      OP_AND: begin alu_res = bus.a & bus.b; alu_upd = 1'b1; alu_wr = 1'b1; end
      OP_OR:  begin alu_res = bus.a | bus.b; alu_upd = 1'b1; alu_wr = 1'b1; end
      OP_XOR: begin alu_res = bus.a ^ bus.b; alu_upd = 1'b1; alu_wr = 1'b1; end
      OP_MOV: begin alu_res = bus.b; alu_wr = 1'b1; end
      OP_SLL, OP_ROL, OP_SRL, OP_SRA: begin
        if (bus.shamt == '0) begin
          alu_res = bus.b;
          alu_upd = 1'b1;
          alu_wr  = 1'b1;
        end else begin
          start_shift = 1'b1;
        end
      end
`ifdef ALU_MUL_EN
      OP_MUL: start_mul = 1'b1;
`endif
      default: ;
    endcase
    alu_fres = (bus.opcode == OP_CMP) ? sub_w[WIDTH-1:0] : alu_res;
  end

  // One bit per cycle; sop_q is opcode[1:0]: 0 SLL, 1 ROL, 2 SRL, 3 SRA.
  always_comb begin
    sh_d  = sh_q;
    shc_d = 1'b0;
    case (sop_q)
      2'd0: begin sh_d = {sh_q[WIDTH-2:0], 1'b0};        shc_d = sh_q[WIDTH-1]; end
      2'd1: begin sh_d = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]}; shc_d = 1'b0;        end
      2'd2: begin sh_d = {1'b0, sh_q[WIDTH-1:1]};        shc_d = sh_q[0];       end
      default: begin sh_d = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]}; shc_d = sh_q[0]; end
    endcase
  end

`ifdef ALU_MUL_EN
  // Upper half accumulates the multiplicand; the pair shifts right as multiplier bits are consumed.
  assign mul_sum = {1'b0, mul_q[2*WIDTH-1:WIDTH]} + (mul_q[0] ? {1'b0, mca_q} : '0);
  assign mul_d   = {mul_sum, mul_q[WIDTH-1:1]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      out_wr_q <= 1'b0;
      fs_q     <= 1'b0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      fv_q     <= 1'b0;
      halted_q <= 1'b0;
      sh_q     <= '0;
      sop_q    <= '0;
      cnt_q    <= '0;
`ifdef ALU_MUL_EN
      mul_q    <= '0;
      mca_q    <= '0;
`endif
    end else if (bus.flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        SHIFT: begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q  <= DONE;
            result_q <= sh_d;
            out_wr_q <= 1'b1;
            fs_q     <= sh_d[WIDTH-1];
            fz_q     <= (sh_d == '0);
            fc_q     <= shc_d;
            fv_q     <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          mul_q <= mul_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q  <= DONE;
            result_q <= mul_d[WIDTH-1:0];
            out_wr_q <= 1'b1;
            fs_q     <= mul_d[WIDTH-1];
            fz_q     <= (mul_d[WIDTH-1:0] == '0);
            fc_q     <= (mul_d[2*WIDTH-1:WIDTH] != '0);
            fv_q     <= (mul_d[2*WIDTH-1:WIDTH] != '0);
          end
        end
`endif
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: ;
      endcase

      if (accept) begin
        if (bus.opcode == OP_HLT) halted_q <= 1'b1;
        if (start_shift) begin
          state_q <= SHIFT;
          sh_q    <= bus.b;
          cnt_q   <= {1'b0, bus.shamt};
          sop_q   <= bus.opcode[1:0];
`ifdef ALU_MUL_EN
        end else if (start_mul) begin
          state_q <= MUL;
          mul_q   <= {{WIDTH{1'b0}}, bus.b};
          mca_q   <= bus.a;
          cnt_q   <= CNT_MUL;
`endif
        end else begin
          state_q  <= DONE;
          result_q <= alu_res;
          out_wr_q <= alu_wr;
          if (alu_upd) begin
            fs_q <= alu_fres[WIDTH-1];
            fz_q <= (alu_fres == '0);
            fc_q <= alu_c;
            fv_q <= alu_v;
          end
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.out_wr    = out_wr_q;
  assign bus.flag_s    = fs_q;
  assign bus.flag_z    = fz_q;
  assign bus.flag_c    = fc_q;
  assign bus.flag_v    = fv_q;
  assign bus.halted    = halted_q;
  assign bus.dbg_state = state_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the single-cycle combinational ALU in the execute stage. It takes one operation through a valid/ready handshake and computes it in one cycle (arithmetic/logic) or iteratively (shifts one bit per cycle, optional shift-add multiply). Flags S/Z/C/V and a sticky halt are held in registers inside the block. The result is held stable until the downstream stage accepts it.

## Interface
Parameters:
- WIDTH, 16, datapath width in bits (≥4, power of two)
- SHW, $clog2(WIDTH), shift-amount width (localparam, derived)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept
- opcode  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP, 6 MOV, 8 SLL, 9 ROL, 10 SRL, 11 SRA, 12 MUL, 15 HLT; others NOP
- a  in  WIDTH  first operand (Rd)
- b  in  WIDTH  second operand (Rs / shift source)
- shamt  in  SHW  shift amount d
- flush  in  1  abort in-flight op
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- result  out  WIDTH  operation result
- out_wr  out  1  result must be written back
- flag_s, flag_z, flag_c, flag_v  out  1 each  architectural flag register
- halted  out  1  sticky halt

## Operation
- FSM states: IDLE, SHIFT, MUL, DONE. Accept = in_valid & in_ready.
- in_ready = (IDLE | (DONE & out_ready)) & ~halted & ~flush. This allows back-to-back issue.
- One-cycle ops: ADD, SUB, logic, CMP, MOV, NOP, HLT, and shifts with d=0. On accept they go straight to DONE with the result registered.
- ADD/SUB: computed at WIDTH+1 bits.
  - S = result MSB; Z = (result==0).
  - ADD: C = unsigned carry-out.
  - SUB: C = borrow (a<b unsigned).
  - V = signed overflow.
- AND/OR/XOR: S, Z from result; C=V=0.
- CMP: flags as SUB; result=a; out_wr=0.
- MOV: result=b; flags unchanged.
- NOP: result=0; out_wr=0; flags unchanged.
- Shifts with d>0: on accept, load b and count=d, then enter SHIFT. Each cycle shifts one bit and decrements; when count reaches 0, go to DONE.
  - SLL and SRL fill with 0; SRA fills with the sign bit; ROL rotates.
  - C = last bit shifted out (C=0 for ROL and for d=0); V=0; S, Z from result.
- HLT: result=0; out_wr=0; halted←1 on accept. in_ready stays 0 until rst. A HLT that is still in DONE still retires.
- Flags update in the cycle the result enters DONE, not at retire. out_wr=1 for all result-writing ops.
- DONE holds result, out_wr and out_valid stable until out_ready. It then returns to IDLE, or loads the next op if one is accepted in the same cycle.
- flush: state←IDLE and out_valid←0 next cycle. Any in-flight or DONE result is discarded and flags are not updated by it. flush wins over a simultaneous accept.
- rst: state IDLE, out_valid 0, result 0, out_wr 0, all flags 0, halted 0. This applies equally mid-SHIFT or mid-MUL.

## Timing
- Latency is counted from the accept edge to the first cycle out_valid=1:
  - one-cycle ops: 1
  - shift with d>0: 1+d
  - MUL: 1+WIDTH
- out_valid is high only in DONE; in_ready is combinational from state, halted, flush and out_ready.
- Throughput with out_ready held at 1: one one-cycle op per clock.
- A flush in DONE in the same cycle as out_ready: the result is discarded. The consumer must ignore out_valid whenever flush=1.

## Configuration
- ALU_MUL_EN defined: opcode 12 is an unsigned shift-add multiply over WIDTH cycles in state MUL.
  - result = low WIDTH bits of a×b.
  - S, Z from result; C = V = (high half ≠ 0).
- ALU_MUL_EN undefined: MUL state and datapath are absent; opcode 12 behaves as NOP with latency 1.

## Test plan
- ADD a=0x7FFF, b=0x0001 -> result 0x8000, S1 Z0 C0 V1, out_valid 1 cycle after accept; SUB 0x0000−0x0001 -> 0xFFFF, S1 Z0 C1 V0.
- SRA b=0x8005, d=3 -> out_valid exactly 4 cycles after accept, result 0xF000, C1 V0 S1 Z0; SLL d=0 -> latency 1, C0.
- out_ready held 0 for 3 cycles in DONE -> result/out_valid stable and in_ready 0; then out_ready=1 with a new op -> retire and accept in the same cycle, next result 1 cycle later.
- Flush 3 cycles into SLL d=10 -> IDLE next cycle, no out_valid, flags unchanged from before the op; simultaneous in_valid not accepted.
- HLT -> halted=1, in_ready=0 permanently, out_wr=0; rst -> halted=0, all flags 0, in_ready=1.
- With ALU_MUL_EN: 0x0003×0x0005 -> 0x000F after 17 cycles, C0 V0; 0x0100×0x0100 -> 0x0000, Z1 C1 V1. Without it: opcode 12 -> latency 1, out_wr=0, flags unchanged.
